// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the timer sequencing controller.
// Struct widths follow the package defaults; instantiate with matching WIDTH/PRESCALE_WIDTH.
package timer_ctrl_pkg;

  localparam int unsigned TimerWidth         = 16;
  localparam int unsigned TimerPrescaleWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef struct packed {
    logic [TimerWidth-1:0]         period;
    logic                          periodic;
    logic [TimerPrescaleWidth-1:0] prescale;
  } cfg_t;

  function automatic logic state_busy(state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Config/control bundle between a register master and timer_ctrl.
interface timer_ctrl_if
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH          = TimerWidth,
  parameter int unsigned PRESCALE_WIDTH = TimerPrescaleWidth
);

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [WIDTH-1:0]          cfg_period;
  logic                      cfg_periodic;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                      start;
  logic                      stop;
  logic                      irq_clear;
  logic                      busy;
  logic [WIDTH-1:0]          count;
  logic                      expire;
  logic                      irq;

  modport master (
    output cfg_valid,
    input  cfg_ready,
    output cfg_period,
    output cfg_periodic,
    output cfg_prescale,
    output start,
    output stop,
    output irq_clear,
    input  busy,
    input  count,
    input  expire,
    input  irq
  );

  modport slave (
    input  cfg_valid,
    output cfg_ready,
    input  cfg_period,
    input  cfg_periodic,
    input  cfg_prescale,
    input  start,
    input  stop,
    input  irq_clear,
    output busy,
    output count,
    output expire,
    output irq
  );

endinterface

// File: rtl/timer_count_core.sv
// Enable-gated up-counter datapath; clear has priority over enable.
module timer_count_core
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = TimerWidth
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = data_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: owns start/stop/clear of the counter core, expiry and irq.
// Prescaler is built only when TIMER_CTRL_PRESCALER_EN is defined.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH          = TimerWidth,
  parameter int unsigned PRESCALE_WIDTH = TimerPrescaleWidth
) (
  input logic         clk,
  input logic         nreset,
  timer_ctrl_if.slave bus_io
);

  state_e           state_q;
  cfg_t             cfg_q;
  cfg_t             cfg_in;
  logic             expire_q;
  logic             irq_q;
  logic             cfg_fire;
  logic             tick;
  logic             term;
  logic             cnt_en;
  logic             cnt_clr;
  logic [WIDTH-1:0] count;

  assign cfg_fire = bus_io.cfg_valid && bus_io.cfg_ready;

  always_comb begin
    cfg_in          = '0;
    cfg_in.period   = bus_io.cfg_period;
    cfg_in.periodic = bus_io.cfg_periodic;
`ifdef TIMER_CTRL_PRESCALER_EN
    cfg_in.prescale = bus_io.cfg_prescale;
`endif
  end

`ifdef TIMER_CTRL_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      pre_hit;

  assign pre_hit = (pre_q == cfg_q.prescale);

  always_comb begin
    pre_d = pre_q;
    if (state_q == StLoad) begin
      pre_d = '0;
    end else if (state_q == StRun) begin
      pre_d = pre_hit ? '0 : pre_q + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = (state_q == StRun) && pre_hit;
`else
  // Prescale config is accepted on the bus but has no effect in this build.
  logic [PRESCALE_WIDTH-1:0] unused_prescale;
  assign unused_prescale = bus_io.cfg_prescale | cfg_q.prescale;

  assign tick = (state_q == StRun);
`endif

  assign term = tick && (count == cfg_q.period);

  // Clear on the way into LOAD so the LOAD cycle already reads zero.
  assign cnt_clr = ((state_q == StIdle) && bus_io.start) ||
                   (state_q == StLoad) ||
                   (term && !bus_io.stop && cfg_q.periodic);
  assign cnt_en  = tick && !term && !bus_io.stop;

  timer_count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .clk    (clk),
    .nreset (nreset),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .data_o (count)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= StIdle;
      cfg_q    <= '0;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      // Set (from the expire pulse) wins over a coincident clear.
      irq_q    <= expire_q | (irq_q & ~bus_io.irq_clear);
      if (cfg_fire) begin
        cfg_q <= cfg_in;
      end
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          state_q <= bus_io.stop ? StIdle : StRun;
        end
        StRun: begin
          if (bus_io.stop) begin
            state_q <= StIdle;
          end else if (term) begin
            expire_q <= 1'b1;
            if (!cfg_q.periodic) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.cfg_ready = (state_q == StIdle) && nreset;
  assign bus_io.busy      = state_busy(state_q);
  assign bus_io.count     = count;
  assign bus_io.expire    = expire_q;
  assign bus_io.irq       = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl; expectations follow TIMER_CTRL_PRESCALER_EN.
module tb_timer_ctrl;

`ifdef TIMER_CTRL_PRESCALER_EN
  localparam bit PreEn = 1'b1;
`else
  localparam bit PreEn = 1'b0;
`endif

  logic clk;
  logic nreset;
  int   checks;
  int   errors;

  timer_ctrl_if #(.WIDTH(16), .PRESCALE_WIDTH(8)) bus ();

  timer_ctrl #(
    .WIDTH          (16),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [15:0] p, input logic per, input logic [7:0] pre);
    bus.cfg_valid    = 1'b1;
    bus.cfg_period   = p;
    bus.cfg_periodic = per;
    bus.cfg_prescale = pre;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic clear_irq();
    bus.irq_clear = 1'b1;
    step();
    bus.irq_clear = 1'b0;
  endtask

  task automatic test_reset();
    step(); step(); step();
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++;
      $display("FAIL reset_cfg_ready_low: got %b expected 0", bus.cfg_ready); end
    nreset = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL reset_cfg_ready_high: got %b expected 1", bus.cfg_ready); end
    checks++; if (bus.count !== 16'd0 || bus.irq !== 1'b0 || bus.expire !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: got count=%0d irq=%b expire=%b expected 0/0/0",
               bus.count, bus.irq, bus.expire); end
    // Reset shadow is P=0 one-shot: expire in cycle 3.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    checks++; if (bus.expire !== 1'b0) begin errors++;
      $display("FAIL reset_shadow_c2: got expire=%b expected 0", bus.expire); end
    step();
    checks++; if (bus.expire !== 1'b1 || bus.count !== 16'd0) begin errors++;
      $display("FAIL reset_shadow_c3: got expire=%b count=%0d expected 1/0",
               bus.expire, bus.count); end
    step();
    checks++; if (bus.irq !== 1'b1 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_shadow_c4: got irq=%b busy=%b expected 1/0", bus.irq, bus.busy); end
    // Mid-run reset
    do_cfg(16'd10, 1'b1, 8'd0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step(); step();
    checks++; if (bus.count !== 16'd2) begin errors++;
      $display("FAIL midrun_count: got %0d expected 2", bus.count); end
    nreset = 1'b0;
    step();
    checks++; if (bus.count !== 16'd0 || bus.expire !== 1'b0 || bus.irq !== 1'b0 ||
                  bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++;
      $display("FAIL midrun_reset: got count=%0d expire=%b irq=%b busy=%b rdy=%b expected 0/0/0/0/0",
               bus.count, bus.expire, bus.irq, bus.busy, bus.cfg_ready); end
    step(); step(); step(); step();
    nreset = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL midrun_release_ready: got %b expected 1", bus.cfg_ready); end
    // Shadow must be back to P=0, not P=10.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step();
    checks++; if (bus.expire !== 1'b1) begin errors++;
      $display("FAIL midrun_shadow_cleared: got expire=%b expected 1", bus.expire); end
    step();
    clear_irq();
  endtask

  task automatic test_one_shot();
    logic [15:0] exp_cnt;
    do_cfg(16'd3, 1'b0, 8'd0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    checks++; if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL one_shot_load: got count=%0d busy=%b expected 0/1", bus.count, bus.busy); end
    for (int c = 2; c <= 7; c++) begin
      step();
      exp_cnt = (c <= 5) ? 16'(c - 2) : 16'd3;
      checks++; if (bus.count !== exp_cnt) begin errors++;
        $display("FAIL one_shot_count c=%0d: got %0d expected %0d", c, bus.count, exp_cnt); end
      checks++; if (bus.expire !== (c == 6)) begin errors++;
        $display("FAIL one_shot_expire c=%0d: got %b expected %b", c, bus.expire, (c == 6)); end
      checks++; if (bus.busy !== (c != 7)) begin errors++;
        $display("FAIL one_shot_busy c=%0d: got %b expected %b", c, bus.busy, (c != 7)); end
    end
    checks++; if (bus.irq !== 1'b1) begin errors++;
      $display("FAIL one_shot_irq: got %b expected 1", bus.irq); end
    clear_irq();
  endtask

  task automatic test_periodic();
    int per_cyc;
    int first;
    per_cyc = PreEn ? 15 : 5;
    first   = per_cyc + 2;
    do_cfg(16'd4, 1'b1, 8'd2);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 2; c <= first + 2 * per_cyc + 1; c++) begin
      step();
      bus.irq_clear = 1'b0;
      checks++;
      if (bus.expire !== (c >= first && ((c - first) % per_cyc) == 0)) begin errors++;
        $display("FAIL periodic_expire c=%0d: got %b", c, bus.expire); end
      if (c == first) begin
        checks++; if (bus.count !== 16'd0) begin errors++;
          $display("FAIL periodic_count_wrap: got %0d expected 0", bus.count); end
      end
      if (c == first + 1) begin
        checks++; if (bus.irq !== 1'b1) begin errors++;
          $display("FAIL periodic_irq_set: got %b expected 1", bus.irq); end
      end
      if (c == first + 2) bus.irq_clear = 1'b1;
      if (c == first + 3) begin
        checks++; if (bus.irq !== 1'b0) begin errors++;
          $display("FAIL periodic_irq_clear: got %b expected 0", bus.irq); end
      end
      if (c == first + per_cyc + 1) begin
        checks++; if (bus.irq !== 1'b1) begin errors++;
          $display("FAIL periodic_irq_rearm: got %b expected 1", bus.irq); end
      end
      if (c == first + per_cyc + 2) bus.irq_clear = 1'b1;
      if (c == first + 2 * per_cyc) begin
        checks++; if (bus.irq !== 1'b0) begin errors++;
          $display("FAIL periodic_irq_pre_coincident: got %b expected 0", bus.irq); end
        bus.irq_clear = 1'b1;
      end
      if (c == first + 2 * per_cyc + 1) begin
        checks++; if (bus.irq !== 1'b1) begin errors++;
          $display("FAIL periodic_irq_set_wins: got %b expected 1", bus.irq); end
      end
    end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL periodic_stop_busy: got %b expected 0", bus.busy); end
    clear_irq();
  endtask

  task automatic test_stop_terminal();
    do_cfg(16'd2, 1'b1, 8'd0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step(); step();
    checks++; if (bus.count !== 16'd2 || bus.expire !== 1'b0) begin errors++;
      $display("FAIL stop_pre: got count=%0d expire=%b expected 2/0", bus.count, bus.expire); end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.count !== 16'd2 || bus.expire !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL stop_terminal: got count=%0d expire=%b busy=%b expected 2/0/0",
               bus.count, bus.expire, bus.busy); end
    step();
    checks++; if (bus.count !== 16'd2 || bus.expire !== 1'b0 || bus.irq !== 1'b0) begin errors++;
      $display("FAIL stop_hold: got count=%0d expire=%b irq=%b expected 2/0/0",
               bus.count, bus.expire, bus.irq); end
  endtask

  task automatic test_cfg_in_run();
    do_cfg(16'd5, 1'b0, 8'd0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    bus.cfg_valid    = 1'b1;
    bus.cfg_period   = 16'd1;
    bus.cfg_periodic = 1'b1;
    bus.cfg_prescale = 8'd0;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++;
      $display("FAIL cfg_run_ready: got %b expected 0", bus.cfg_ready); end
    for (int c = 3; c <= 9; c++) begin
      step();
      if (c == 4) begin
        checks++; if (bus.expire !== 1'b0) begin errors++;
          $display("FAIL cfg_run_shadow_kept: got expire=%b expected 0", bus.expire); end
      end
      if (c == 8) begin
        checks++; if (bus.expire !== 1'b1 || bus.cfg_ready !== 1'b0) begin errors++;
          $display("FAIL cfg_run_expire: got expire=%b rdy=%b expected 1/0",
                   bus.expire, bus.cfg_ready); end
      end
      if (c == 9) begin
        checks++; if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++;
          $display("FAIL cfg_run_first_idle: got rdy=%b busy=%b expected 1/0",
                   bus.cfg_ready, bus.busy); end
      end
    end
    step();
    bus.cfg_valid = 1'b0;
    clear_irq();
    // New config: P=1 periodic, expire in cycles 4 and 6.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++; if (bus.expire !== (c == 4 || c == 6)) begin errors++;
        $display("FAIL cfg_new_expire c=%0d: got %b expected %b", c, bus.expire,
                 (c == 4 || c == 6)); end
    end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    clear_irq();
  endtask

  task automatic test_prescale_build();
    int lat;
    lat = PreEn ? 18 : 4;
    do_cfg(16'd1, 1'b0, 8'd7);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 2; c <= lat + 1; c++) begin
      step();
      checks++; if (bus.expire !== (c == lat)) begin errors++;
        $display("FAIL prescale_latency c=%0d: got %b expected %b", c, bus.expire, (c == lat)); end
    end
    checks++; if (bus.busy !== 1'b0 || bus.count !== 16'd1) begin errors++;
      $display("FAIL prescale_end: got busy=%b count=%0d expected 0/1", bus.busy, bus.count); end
    clear_irq();
  endtask

  initial begin
    clk              = 1'b0;
    nreset           = 1'b0;
    checks           = 0;
    errors           = 0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_period   = '0;
    bus.cfg_periodic = 1'b0;
    bus.cfg_prescale = '0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.irq_clear    = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_stop_terminal();
    test_cfg_in_run();
    test_prescale_build();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
